uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  Transmit side of the UART driver: serialises one byte per write strobe onto TxD.
//  Sits downstream of the debounced button path: a one-cycle deb_buttout pulse (or any core strobe)
//  drives tx_wr and launches exactly one frame. Contains its own 16x baud tick generator.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency; divisor table is computed for this value
//  OVERSAMPLE 16          baud ticks per bit; shared with the receive side
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  tx_en        in   1  transmitter enable; 0 forces idle and aborts any frame
//  tx_wr        in   1  one-cycle write strobe; launches a frame when accepted
//  tx_data      in   8  byte to send; sampled only in the accept cycle
//  baud_select  in   3  rate code 0..7 = 300,1200,4800,9600,19200,38400,57600,115200
//  TxD          out  1  serial line; idle/mark = 1
//  tx_busy      out  1  1 from the cycle after accept until the stop bit completes
// BEHAVIOUR
//  Reset: TxD=1, tx_busy=0, FSM=IDLE, baud counter=0, bit counter=0, shift reg=0.
//  Divisor (clk cycles per tick) = round(CLK_HZ/(16*baud)), codes 0..7 map to
//  10417, 2604, 651, 326, 163, 81, 54, 27.
//  Tick: 1-cycle pulse when baud counter reaches divisor-1; counter then wraps to 0.
//  Accept: tx_wr=1 && tx_en=1 && FSM==IDLE. Latch tx_data and baud_select; clear baud counter.
//    tx_wr in any other state, or with tx_en=0, is ignored (no queueing).
//  FSM IDLE->START->DATA->(PARITY)->STOP->IDLE. Each state holds exactly 16 ticks.
//    START: TxD=0. DATA: 8 bits, LSB first, 3-bit bit counter, 7->0 leaves DATA.
//    PARITY: see CONFIGURATION. STOP: TxD=1.
//  TxD changes on the cycle after accept. After that it changes only on the cycle after a 16th tick.
//  Frame length = 10*16*div cycles (11*16*div with parity).
//    Example: code 7 gives 4320 cycles.
//  tx_busy falls in the same cycle FSM returns to IDLE.
//    A tx_wr in that cycle is accepted, so back-to-back frames have no extra gap.
//  baud_select changes mid-frame have no effect until the next accept.
//  tx_en=0 mid-frame: next cycle FSM=IDLE, TxD=1, tx_busy=0, counters cleared.
//  reset mid-frame: same as reset; no partial stop bit is emitted.
//  tx_wr and reset in the same cycle: reset wins.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA.
//    TxD = ^latched_data (even parity), held 16 ticks.
//  UART_TX_PARITY_EN undefined: no PARITY state; the DATA state goes directly to STOP.
//    Encoding value is reserved and unused.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//    FSM state encodings (IDLE, START, DATA, PARITY, STOP).
//    baud code localparams and the divisor table.
//    OVERSAMPLE; the receive side uses the same values.
//  Sub-module uart_baud_gen: input baud code and a sync clear, output 1-cycle tick.
//    Reused unchanged by the receiver.
//  Top contains the FSM, shift register, bit/tick counters and TxD/tx_busy registers.
// TESTING
//  1. reset held 3 cycles -> TxD=1, tx_busy=0; tx_wr during reset -> no frame.
//  2. code 7, tx_wr with 0x55 -> TxD 0,1,0,1,0,1,0,1,0,1, each 432 cycles.
//     tx_busy high for exactly 4320 cycles.
//  3. tx_wr pulsed again at 1000 cycles into a frame.
//     -> ignored; only one frame appears; the second byte is never sent.
//  4. tx_wr in the cycle tx_busy falls, 0xA3 then 0x0F.
//     -> two frames with zero idle cycles between the stop bit and the next start bit.
//  5. tx_en dropped mid DATA bit 3 -> next cycle TxD=1, tx_busy=0.
//     A new tx_wr after that starts a clean frame.
//  6. UART_TX_PARITY_EN, 0x07 at code 6 -> parity bit 1, frame 11*16*54 = 9504 cycles.
//     Same test with 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling factor and divisor math.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
// Optional feature macro: UART_TX_PARITY_EN (selects whether ST_PARITY is reachable).
package uart_tx_frame_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;  // wide enough for the 300 baud divisor (10417)

    // Frame FSM encodings. ST_PARITY is reserved when parity is not built in.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Rate code to baud rate.
    function automatic int baud_rate(input logic [2:0] code);
        int rate;
        case (code)
            3'd0:    rate = 300;
            3'd1:    rate = 1200;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Clock cycles per baud tick, rounded to nearest: round(clk_hz / (os * baud)).
    // Only ever called with constant arguments, so it folds to a table.
    function automatic int baud_div(input int clk_hz, input int os, input logic [2:0] code);
        int rate;
        rate = baud_rate(code);
        return (clk_hz + (os * rate) / 2) / (os * rate);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Write-side bus of the UART transmitter: enable, strobe, byte, rate code, line and busy.
// Latency: n/a (signal bundle only).
// Backpressure: tx_busy high means tx_wr is dropped, not queued.
// Ports: master drives tx_en/tx_wr/tx_data/baud_select; slave drives TxD/tx_busy.
interface uart_tx_frame_if;
    logic       tx_en;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [2:0] baud_select;
    logic       TxD;
    logic       tx_busy;

    modport master (
        output tx_en, tx_wr, tx_data, baud_select,
        input  TxD, tx_busy
    );

    modport slave (
        input  tx_en, tx_wr, tx_data, baud_select,
        output TxD, tx_busy
    );
endinterface

// File: rtl/uart_tx_frame_baud_gen.sv
// 16x baud tick generator: one-cycle tick every divisor cycles for the selected rate code.
// Latency: first tick divisor cycles after a clear; tick is combinational from the counter.
// Backpressure: none; clr restarts the count so a new frame starts on a clean tick phase.
// Ports: clk, reset (sync, high), clr (sync restart), code[2:0] rate code, tick out.
module uart_baud_gen
    import uart_tx_frame_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [2:0] code,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1 [8];

    // Terminal count per rate code, folded to constants at elaboration.
    for (genvar g = 0; g < 8; g++) begin : g_div
        assign div_m1[g] = DIV_W'(baud_div(CLK_HZ, OVERSAMPLE, 3'(g)) - 1);
    end

    assign tick = (cnt == div_m1[code]);

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one 8N1 frame (8E1 with UART_TX_PARITY_EN) per accepted tx_wr strobe.
// Latency: TxD drops to the start bit the cycle after accept; each bit lasts 16 baud ticks.
// Backpressure: tx_wr while tx_busy (or with tx_en low) is ignored; nothing is queued.
// Ports: clk, reset (sync, high), bus (slave modport: tx_en, tx_wr, tx_data, baud_select in;
//        TxD, tx_busy out). Macro UART_TX_PARITY_EN inserts an even-parity bit after DATA.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);

    logic [2:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [3:0] tick_cnt;
    logic [2:0] code_lat;
    logic       txd_q;
    logic       busy_q;
    logic       tick;
    logic       accept;
    logic       last_tick;
`ifdef UART_TX_PARITY_EN
    logic [7:0] data_lat;
`endif

    assign accept    = bus.tx_wr && bus.tx_en && (state == ST_IDLE);
    assign last_tick = tick && (tick_cnt == 4'd15);

    // Clearing on accept aligns the first tick exactly one divisor after the start bit begins.
    uart_baud_gen #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (accept || !bus.tx_en),
        .code  (code_lat),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            code_lat <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            data_lat <= '0;
`endif
        end else if (!bus.tx_en) begin
            // Abort: line back to mark immediately, no stop bit.
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                state    <= ST_START;
                shreg    <= bus.tx_data;
                code_lat <= bus.baud_select;
                bit_cnt  <= '0;
                tick_cnt <= '0;
                txd_q    <= 1'b0;
                busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                data_lat <= bus.tx_data;
`endif
            end
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (last_tick) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        txd_q <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd_q <= ^data_lat;
`else
                            state <= ST_STOP;
                            txd_q <= 1'b1;
`endif
                        end else begin
                            txd_q <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state <= ST_STOP;
                        txd_q <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.TxD     = txd_q;
    assign bus.tx_busy = busy_q;

endmodule
